measure_avg: RTL and testbench

Post-processing stage directly downstream of sensor_core, clocked on clk_sys. Consumes the done/err/data result of each ultrasonic measurement and keeps a sliding-window average of the last N good samples, computed with a serial divider. Keeps error and drop counters, and exposes results as an 8-bit read-only register window on the fx bus for commu_top.

---
 rtl/measure_avg.sv | 209 ++++++++++++++++++++
 tb/tb_measure_avg.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/measure_avg.sv
// Sliding-window average of the last 2^LOG_N good measurements, divided serially,
// with error/drop counters and an 8-bit read-only register window on the fx bus.
module measure_avg #(
  parameter int          LOG_N     = 3,
  parameter int          DW        = 16,
  parameter logic [21:0] BASE_ADDR = 22'h000100
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          meas_done,
  input  logic          meas_err,
  input  logic [DW-1:0] meas_data,
  input  logic          clr,
  output logic [DW-1:0] avg_data,
  output logic          avg_pulse,
  output logic          avg_vld,
  input  logic          fx_rd,
  input  logic [21:0]   fx_raddr,
  output logic [7:0]    fx_q,
  output logic          fx_hit
);

  localparam int N   = 1 << LOG_N;
  localparam int SW  = DW + LOG_N;
  localparam int CW  = LOG_N + 1;
  localparam int RW  = LOG_N + 2;
  localparam int RSW = LOG_N + 1;
  localparam int DCW = $clog2(SW);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UPD  = 2'd1,
    ST_DIV  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t         state_r;
  logic [DW-1:0]  last_data_r;
  logic [DW-1:0]  buf_r [N];
  logic [LOG_N-1:0] wr_ptr_r;
  logic [CW-1:0]  count_r;
  logic [SW-1:0]  sum_r;
  logic [7:0]     err_cnt_r;
  logic [7:0]     drop_cnt_r;
  logic [SW-1:0]  dvd_r;
  logic [RSW-1:0] rem_r;
  logic [DCW-1:0] step_r;
  logic [DW-1:0]  avg_data_r;
  logic           avg_pulse_r;
  logic           avg_vld_r;
  logic [7:0]     fx_q_r;
  logic           fx_hit_r;

  logic           data_zero_s;
  logic           good_s;
  logic           bad_s;
  logic [DW-1:0]  old_s;
  logic [SW-1:0]  sum_new_s;
  logic [CW-1:0]  count_new_s;
  logic [RW-1:0]  trial_s;
  logic [RW-1:0]  divisor_s;
  logic           ge_s;
  logic           hit_s;
  logic [7:0]     reg_sel_s;

  // Sample classification, window update terms and one restoring-divide step.
  always_comb begin
    data_zero_s = (meas_data == {DW{1'b0}});
    good_s      = meas_done & ~meas_err & ~data_zero_s;
    bad_s       = meas_err | (meas_done & data_zero_s);
    if (count_r == CW'(N)) begin
      old_s       = buf_r[wr_ptr_r];
      count_new_s = count_r;
    end else begin
      old_s       = {DW{1'b0}};
      count_new_s = count_r + CW'(1);
    end
    sum_new_s = sum_r + SW'(last_data_r) - SW'(old_s);
    trial_s   = {rem_r, dvd_r[SW-1]};
    divisor_s = RW'(count_r);
    ge_s      = (trial_s >= divisor_s);
  end

  // Register window decode; only the low nibble selects within the block.
  always_comb begin
    hit_s = fx_rd & (fx_raddr[21:4] == BASE_ADDR[21:4]);
    case (fx_raddr[3:0])
      4'd0:    reg_sel_s = avg_data_r[7:0];
      4'd1:    reg_sel_s = avg_data_r[15:8];
      4'd2:    reg_sel_s = 8'(count_r);
      4'd3:    reg_sel_s = err_cnt_r;
      4'd4:    reg_sel_s = drop_cnt_r;
      4'd5:    reg_sel_s = last_data_r[7:0];
      4'd6:    reg_sel_s = last_data_r[15:8];
      4'd7:    reg_sel_s = {7'b0000000, avg_vld_r};
      default: reg_sel_s = 8'h00;
    endcase
  end

  // Window storage; contents are never cleared because count_r guards them.
  always_ff @(posedge clk_sys) begin
    if (rst_n && !clr && (state_r == ST_UPD)) begin
      buf_r[wr_ptr_r] <= last_data_r;
    end
  end

  // Control FSM, window bookkeeping, serial divider and result outputs.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      last_data_r <= {DW{1'b0}};
      wr_ptr_r    <= {LOG_N{1'b0}};
      count_r     <= {CW{1'b0}};
      sum_r       <= {SW{1'b0}};
      err_cnt_r   <= 8'h00;
      drop_cnt_r  <= 8'h00;
      dvd_r       <= {SW{1'b0}};
      rem_r       <= {RSW{1'b0}};
      step_r      <= {DCW{1'b0}};
      avg_data_r  <= {DW{1'b0}};
      avg_pulse_r <= 1'b0;
      avg_vld_r   <= 1'b0;
    end else if (clr) begin
      state_r     <= ST_IDLE;
      wr_ptr_r    <= {LOG_N{1'b0}};
      count_r     <= {CW{1'b0}};
      sum_r       <= {SW{1'b0}};
      err_cnt_r   <= 8'h00;
      drop_cnt_r  <= 8'h00;
      step_r      <= {DCW{1'b0}};
      avg_data_r  <= {DW{1'b0}};
      avg_pulse_r <= 1'b0;
      avg_vld_r   <= 1'b0;
    end else begin
      avg_pulse_r <= 1'b0;
      if (bad_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
      // A good sample is only taken while idle; otherwise it counts as dropped.
      if (good_s && (state_r != ST_IDLE) && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (good_s) begin
            last_data_r <= meas_data;
            state_r     <= ST_UPD;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_UPD: begin
          sum_r    <= sum_new_s;
          count_r  <= count_new_s;
          wr_ptr_r <= wr_ptr_r + LOG_N'(1);
          dvd_r    <= sum_new_s;
          rem_r    <= {RSW{1'b0}};
          step_r   <= {DCW{1'b0}};
          state_r  <= ST_DIV;
        end
        ST_DIV: begin
          // Quotient bits shift in from the bottom as the dividend shifts out the top.
          rem_r  <= ge_s ? RSW'(trial_s - divisor_s) : RSW'(trial_s);
          dvd_r  <= {dvd_r[SW-2:0], ge_s};
          step_r <= step_r + DCW'(1);
          if (step_r == DCW'(SW - 1)) begin
            state_r <= ST_OUT;
          end else begin
            state_r <= ST_DIV;
          end
        end
        ST_OUT: begin
          avg_data_r  <= dvd_r[DW-1:0];
          avg_pulse_r <= 1'b1;
          avg_vld_r   <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Read port: data and hit are registered together and return pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      fx_q_r   <= 8'h00;
      fx_hit_r <= 1'b0;
    end else if (hit_s) begin
      fx_q_r   <= reg_sel_s;
      fx_hit_r <= 1'b1;
    end else begin
      fx_q_r   <= 8'h00;
      fx_hit_r <= 1'b0;
    end
  end

  assign avg_data  = avg_data_r;
  assign avg_pulse = avg_pulse_r;
  assign avg_vld   = avg_vld_r;
  assign fx_q      = fx_q_r;
  assign fx_hit    = fx_hit_r;

endmodule

// File: tb/tb_measure_avg.sv
// Bench for measure_avg: directed scenarios then random traffic, every cycle
// compared against a queue-based window-average model.
module tb_measure_avg;

  localparam int LOG_N = 3;
  localparam int DW    = 16;
  localparam int N     = 8;
  localparam int LAT   = 2 + DW + LOG_N;
  localparam logic [21:0] BASE = 22'h000100;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        meas_done;
  logic        meas_err;
  logic [15:0] meas_data;
  logic        clr;
  logic [15:0] avg_data;
  logic        avg_pulse;
  logic        avg_vld;
  logic        fx_rd;
  logic [21:0] fx_raddr;
  logic [7:0]  fx_q;
  logic        fx_hit;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  int win[$];
  int cyc        = 0;
  int busy_until = 0;
  int due        = -1;
  int pending    = 0;
  int m_avg      = 0;
  bit m_vld      = 1'b0;
  int m_err_cnt  = 0;
  int m_drop     = 0;
  int m_last     = 0;

  measure_avg #(.LOG_N(LOG_N), .DW(DW), .BASE_ADDR(BASE)) dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .meas_done(meas_done),
    .meas_err (meas_err),
    .meas_data(meas_data),
    .clr      (clr),
    .avg_data (avg_data),
    .avg_pulse(avg_pulse),
    .avg_vld  (avg_vld),
    .fx_rd    (fx_rd),
    .fx_raddr (fx_raddr),
    .fx_q     (fx_q),
    .fx_hit   (fx_hit)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int win_avg();
    int s = 0;
    foreach (win[i]) s += win[i];
    return s / win.size();
  endfunction

  function automatic logic [7:0] exp_reg(input logic [3:0] off);
    case (off)
      4'd0:    return 8'(m_avg);
      4'd1:    return 8'(m_avg >> 8);
      4'd2:    return 8'(win.size());
      4'd3:    return 8'(m_err_cnt);
      4'd4:    return 8'(m_drop);
      4'd5:    return 8'(m_last);
      4'd6:    return 8'(m_last >> 8);
      4'd7:    return {7'd0, m_vld};
      default: return 8'h00;
    endcase
  endfunction

  // One clock: drive inputs, advance the model at the edge, check all outputs.
  task automatic step(input bit d, input bit e, input logic [15:0] data,
                      input bit c, input bit rd, input logic [21:0] addr);
    int          e_idx;
    bit          exp_pulse;
    bit          exp_hit;
    logic [7:0]  exp_q;
    bit          good;
    bit          bad;
    e_idx = cyc + 1;
    if (e_idx <= busy_until) rd = 1'b0;
    meas_done = d; meas_err = e; meas_data = data; clr = c;
    fx_rd = rd; fx_raddr = addr;
    exp_hit = rd && (addr[21:4] == BASE[21:4]);
    exp_q   = exp_hit ? exp_reg(addr[3:0]) : 8'h00;
    @(posedge clk_sys);
    cyc = e_idx;
    exp_pulse = 1'b0;
    good = d && !e && (data != 16'd0);
    bad  = e || (d && (data == 16'd0));
    if (c) begin
      win.delete();
      m_avg = 0; m_vld = 1'b0; m_err_cnt = 0; m_drop = 0;
      due = -1; busy_until = 0;
    end else begin
      if (due == cyc) begin
        exp_pulse = 1'b1; m_avg = pending; m_vld = 1'b1; due = -1;
      end
      if (good) begin
        if (cyc > busy_until) begin
          m_last = data;
          win.push_back(int'(data));
          if (win.size() > N) void'(win.pop_front());
          pending    = win_avg();
          due        = cyc + LAT;
          busy_until = due;
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
      if (bad && m_err_cnt < 255) m_err_cnt++;
    end
    #1;
    meas_done = 1'b0; meas_err = 1'b0; meas_data = 16'd0; clr = 1'b0; fx_rd = 1'b0;
    check("avg_pulse", 32'(avg_pulse), 32'(exp_pulse));
    check("avg_data",  32'(avg_data),  32'(m_avg));
    check("avg_vld",   32'(avg_vld),   32'(m_vld));
    check("fx_q",      32'(fx_q),      32'(exp_q));
    check("fx_hit",    32'(fx_hit),    32'(exp_hit));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 22'd0);
  endtask

  task automatic good(input logic [15:0] v);
    step(1'b1, 1'b0, v, 1'b0, 1'b0, 22'd0);
  endtask

  task automatic rd_reg(input logic [21:0] addr);
    step(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, addr);
  endtask

  task automatic do_clr();
    step(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 22'd0);
  endtask

  initial begin
    int r;
    logic [21:0] a;
    rst_n = 1'b0; meas_done = 1'b0; meas_err = 1'b0; meas_data = 16'd0;
    clr = 1'b0; fx_rd = 1'b0; fx_raddr = 22'd0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_avg_data",  32'(avg_data),  32'd0);
    check("rst_avg_pulse", 32'(avg_pulse), 32'd0);
    check("rst_avg_vld",   32'(avg_vld),   32'd0);
    check("rst_fx_q",      32'(fx_q),      32'd0);
    check("rst_fx_hit",    32'(fx_hit),    32'd0);
    rst_n = 1'b1;
    rd_reg(BASE + 22'd2);
    rd_reg(BASE + 22'd3);

    // single sample: pulse LAT cycles later
    good(16'd100);
    idle(LAT + 4);
    check("single_avg", 32'(avg_data), 32'd100);
    rd_reg(BASE + 22'd2);
    check("single_count", 32'(fx_q), 32'd1);
    rd_reg(BASE + 22'd7);
    check("single_vld_reg", 32'(fx_q), 32'd1);

    // 10, 20, 30 spaced 30 cycles
    do_clr();
    good(16'd10); idle(29);
    check("seq_avg1", 32'(avg_data), 32'd10);
    good(16'd20); idle(29);
    check("seq_avg2", 32'(avg_data), 32'd15);
    good(16'd30); idle(29);
    check("seq_avg3", 32'(avg_data), 32'd20);

    // 1..10: window wraps to 3..10
    do_clr();
    for (int i = 1; i <= 10; i++) begin
      good(16'(i)); idle(29);
    end
    check("wrap_avg", 32'(avg_data), 32'd6);
    rd_reg(BASE + 22'd2);
    check("wrap_count", 32'(fx_q), 32'd8);

    // drop while busy, explicit error, zero data as error
    do_clr();
    good(16'd40); idle(4);
    good(16'd60); idle(2);
    step(1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 22'd0); idle(2);
    step(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 22'd0); idle(30);
    rd_reg(BASE + 22'd4);
    check("drop_cnt", 32'(fx_q), 32'd1);
    rd_reg(BASE + 22'd3);
    check("err_cnt", 32'(fx_q), 32'd2);
    rd_reg(BASE + 22'd5);
    check("last_lo", 32'(fx_q), 32'd40);

    // clr aborts an in-flight divide
    do_clr();
    good(16'd90); idle(7);
    do_clr();
    idle(30);
    for (int o = 0; o <= 7; o++) begin
      if (o != 5 && o != 6) begin
        rd_reg(BASE + 22'(o));
        check("clr_reg", 32'(fx_q), 32'd0);
      end
    end
    good(16'd50); idle(LAT + 2);
    check("post_clr_avg", 32'(avg_data), 32'd50);

    // error counter saturation and an address outside the window
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 22'd0);
    rd_reg(BASE + 22'd3);
    check("err_sat_q", 32'(fx_q), 32'hFF);
    check("err_sat_hit", 32'(fx_hit), 32'd1);
    rd_reg(BASE + 22'd16);
    check("miss_q", 32'(fx_q), 32'd0);
    check("miss_hit", 32'(fx_hit), 32'd0);

    // random traffic
    do_clr();
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      a = ($urandom_range(0, 3) != 0) ? {BASE[21:4], 4'($urandom)} : 22'($urandom);
      if (r < 40)
        step(1'b1, 1'b0, 16'($urandom_range(1, 65535)), 1'b0, 1'b0, 22'd0);
      else if (r < 50)
        step(1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 22'd0);
      else if (r < 65)
        step($urandom_range(0, 1) == 1, 1'b1, 16'($urandom), 1'b0, 1'b0, 22'd0);
      else if (r < 70)
        step(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 22'd0);
      else if (r < 73)
        step(1'b1, 1'b0, 16'($urandom), 1'b1, 1'b0, 22'd0);
      else if (r < 200)
        step(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, a);
      else
        idle(1);
    end
    idle(LAT + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
